mel_frame_ctrl: RTL and testbench

MEL_FRAME_CTRL -- requirements
Module: mel_frame_ctrl

---
 rtl/mel_pkg.sv | 15 +
 rtl/mel_idx_counter.sv | 27 ++
 rtl/mel_frame_ctrl.sv | 138 +++++++++++++
 tb/tb_mel_frame_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mel_pkg.sv
// Shared sizing constants and FSM state encoding for the mel frame controller.
package mel_pkg;
    localparam int MEL_N_BINS = 513;
    localparam int MEL_N_MEL  = 64;
    localparam int MEL_FV_W   = 10;
    localparam int MEL_RI_W   = 6;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STREAM  = 3'd1,
        S_DRAIN   = 3'd2,
        S_READOUT = 3'd3,
        S_DONE    = 3'd4
    } mel_state_t;
endpackage

// File: rtl/mel_idx_counter.sv
// Wrap-length index counter: clear has priority, wraps to 0 after LEN-1.
module mel_idx_counter #(
    parameter int LEN = 64,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_last
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_last = (r_cnt == W'(LEN - 1));
endmodule

// File: rtl/mel_frame_ctrl.sv
// Frame sequencer for mel filterbank: streams FFT bins to the coefficient
// block, drains its pipeline, then reads out each mel band.
module mel_frame_ctrl
    import mel_pkg::*;
#(
    parameter int I_BW     = 14,
    parameter int N_BINS   = MEL_N_BINS,
    parameter int N_MEL    = MEL_N_MEL,
    parameter int COEF_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic                busy,
    input  logic                di_valid,
    input  logic [I_BW-1:0]     di_data,
    output logic                di_ready,
    output logic                co_en,
    output logic [I_BW-1:0]     co_data,
    output logic [MEL_FV_W-1:0] filter_v,
    output logic                last_bin,
    output logic                acc_clr,
    output logic                rd_en,
    output logic [MEL_RI_W-1:0] rd_idx,
    input  logic                rd_ready,
    output logic                frame_done,
    output logic [15:0]         frame_cnt
);
    localparam int DW = $clog2(COEF_LAT + 2);

    mel_state_t r_state, w_state_next;

    logic                r_busy, r_di_ready, r_co_en, r_last_bin;
    logic                r_acc_clr, r_rd_en, r_frame_done;
    logic [I_BW-1:0]     r_co_data;
    logic [MEL_FV_W-1:0] r_filter_v;
    logic [15:0]         r_frame_cnt;
    logic [DW-1:0]       r_drain_cnt;

    logic                w_xfer, w_rd_acc, w_start_go, w_cnt_clr;
    logic                w_bin_last, w_rd_last;
    logic [MEL_FV_W-1:0] w_bin_cnt;
    logic [MEL_RI_W-1:0] w_rd_idx;

    // Abort wins over both a same-cycle transfer and a new start.
    assign w_xfer     = (r_state == S_STREAM) && di_valid && r_di_ready && !abort;
    assign w_rd_acc   = (r_state == S_READOUT) && r_rd_en && rd_ready && !abort;
    assign w_start_go = start && !abort && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_cnt_clr  = w_start_go || abort;

    mel_idx_counter #(.LEN(N_BINS), .W(MEL_FV_W)) u_bin_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_xfer),
        .o_cnt  (w_bin_cnt),
        .o_last (w_bin_last)
    );

    mel_idx_counter #(.LEN(N_MEL), .W(MEL_RI_W)) u_rd_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_cnt_clr),
        .i_en   (w_rd_acc),
        .o_cnt  (w_rd_idx),
        .o_last (w_rd_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_start_go) w_state_next = S_STREAM;
            S_STREAM:  if (w_xfer && w_bin_last) w_state_next = S_DRAIN;
            // DRAIN spans the last co_en cycle plus COEF_LAT+1 wait cycles.
            S_DRAIN:   if (r_drain_cnt == DW'(COEF_LAT + 1)) w_state_next = S_READOUT;
            S_READOUT: if (w_rd_acc && w_rd_last) w_state_next = S_DONE;
            S_DONE:    w_state_next = w_start_go ? S_STREAM : S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy       <= 1'b0;
            r_acc_clr    <= 1'b0;
            r_di_ready   <= 1'b0;
            r_rd_en      <= 1'b0;
            r_frame_done <= 1'b0;
            r_co_en      <= 1'b0;
            r_last_bin   <= 1'b0;
            r_co_data    <= '0;
            r_filter_v   <= '0;
            r_frame_cnt  <= '0;
            r_drain_cnt  <= '0;
        end else begin
            r_busy       <= (w_state_next != S_IDLE);
            r_acc_clr    <= w_start_go;
            r_di_ready   <= (w_state_next == S_STREAM) && !w_start_go;
            r_rd_en      <= (w_state_next == S_READOUT);
            r_frame_done <= (w_state_next == S_DONE);
            r_co_en      <= w_xfer;
            r_last_bin   <= w_xfer && w_bin_last;
            if (w_xfer) begin
                r_co_data  <= di_data;
                r_filter_v <= w_bin_cnt;
            end
            if ((r_state == S_READOUT) && (w_state_next == S_DONE)) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_drain_cnt <= ((r_state == S_DRAIN) && (w_state_next == S_DRAIN)) ?
                           r_drain_cnt + 1'b1 : '0;
        end
    end

    assign busy       = r_busy;
    assign di_ready   = r_di_ready;
    assign co_en      = r_co_en;
    assign co_data    = r_co_data;
    assign filter_v   = r_filter_v;
    assign last_bin   = r_last_bin;
    assign acc_clr    = r_acc_clr;
    assign rd_en      = r_rd_en;
    assign rd_idx     = w_rd_idx;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;
endmodule

// File: tb/tb_mel_frame_ctrl.sv
// Self-checking bench for mel_frame_ctrl: randomized bin/readout handshakes
// compared against an in-bench model of the expected frame sequence.
module tb_mel_frame_ctrl;
    import mel_pkg::*;

    localparam int I_BW = 14;
    localparam int NB   = MEL_N_BINS;
    localparam int NM   = MEL_N_MEL;
    localparam int CL   = 1;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic di_valid = 1'b0, rd_ready = 1'b0;
    logic [I_BW-1:0] di_data = '0;
    logic busy, di_ready, co_en, last_bin, acc_clr, rd_en, frame_done;
    logic [I_BW-1:0] co_data;
    logic [9:0] filter_v;
    logic [5:0] rd_idx;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frames = 0;

    // Observed co_en beats, model of accepted bin data, accepted mel indices.
    int q_fv[$];
    logic [I_BW-1:0] q_cd[$];
    int q_lb[$];
    logic [I_BW-1:0] q_exp[$];
    int q_rd[$];
    int n_acc_clr, n_done, n_cyc, last_co_cyc, first_rd_cyc, hold_cnt;
    bit timed_out;

    always #5 clk = ~clk;

    mel_frame_ctrl #(.I_BW(I_BW), .N_BINS(NB), .N_MEL(NM), .COEF_LAT(CL)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .di_valid   (di_valid),
        .di_data    (di_data),
        .di_ready   (di_ready),
        .co_en      (co_en),
        .co_data    (co_data),
        .filter_v   (filter_v),
        .last_bin   (last_bin),
        .acc_clr    (acc_clr),
        .rd_en      (rd_en),
        .rd_idx     (rd_idx),
        .rd_ready   (rd_ready),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    // vmode: 0 valid always, 1 toggling, 2 random. Negative index args disable a feature.
    task automatic run_frame(input int vmode, input int stall_idx, input int stall_len,
                             input int abort_bin, input int stream_start_bin,
                             input bit start_in_done, input bit pre_started, input int stop_rd_idx);
        int  stall_left = stall_len;
        bit  tog = 1'b1;
        bit  finished = 1'b0;
        q_fv.delete(); q_cd.delete(); q_lb.delete(); q_exp.delete(); q_rd.delete();
        n_acc_clr = 0; n_done = 0; n_cyc = 0; hold_cnt = 0;
        last_co_cyc = -1; first_rd_cyc = -1; timed_out = 1'b0;
        if (!pre_started) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        while (!finished) begin
            if (co_en) begin
                q_fv.push_back(int'(filter_v));
                q_cd.push_back(co_data);
                q_lb.push_back(int'(last_bin));
                last_co_cyc = n_cyc;
            end
            if (acc_clr) n_acc_clr++;
            if (rd_en && first_rd_cyc < 0) first_rd_cyc = n_cyc;
            if (frame_done) n_done++;
            if (stop_rd_idx >= 0 && rd_en && int'(rd_idx) == stop_rd_idx) break;

            start = 1'b0;
            abort = 1'b0;
            case (vmode)
                0:       di_valid = 1'b1;
                1:       di_valid = tog;
                default: di_valid = 1'($urandom_range(0, 1));
            endcase
            tog = ~tog;
            di_data = I_BW'($urandom);
            if (abort_bin >= 0 && di_ready && q_exp.size() == abort_bin) begin
                abort = 1'b1;
                di_valid = 1'b1;
                finished = 1'b1;
            end else if (di_ready && di_valid) begin
                q_exp.push_back(di_data);
            end
            if (stream_start_bin >= 0 && q_exp.size() == stream_start_bin) start = 1'b1;

            rd_ready = 1'b1;
            if (rd_en && int'(rd_idx) == stall_idx && stall_left > 0) begin
                rd_ready = 1'b0;
                stall_left--;
                hold_cnt++;
            end
            if (rd_en && rd_ready) q_rd.push_back(int'(rd_idx));
            if (frame_done) begin
                finished = 1'b1;
                if (start_in_done) start = 1'b1;
            end
            @(posedge clk); #1;
            n_cyc++;
            if (n_cyc > 5000) begin
                timed_out = 1'b1;
                finished = 1'b1;
            end
        end
        start = 1'b0; abort = 1'b0; di_valid = 1'b0; rd_ready = 1'b0;
        $display("frame: co_en beats=%0d rd beats=%0d done=%0d frame_cnt=%0d",
                 q_fv.size(), q_rd.size(), n_done, frame_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, di_ready, co_en, last_bin, acc_clr, rd_en, frame_done} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {busy, di_ready, co_en, last_bin, acc_clr, rd_en, frame_done});
        end
        n_checks++;
        if (frame_cnt !== 16'd0 || filter_v !== 10'd0 || rd_idx !== 6'd0 || co_data !== '0) begin
            n_fail++;
            $display("FAIL reset_values: frame_cnt=%0d filter_v=%0d rd_idx=%0d co_data=%0d expected all 0",
                     frame_cnt, filter_v, rd_idx, co_data);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
    endtask

    // Full frame with di_valid held high and rd_ready always high.
    task automatic test_full_frame();
        run_frame(0, -1, 0, -1, -1, 1'b0, 1'b0, -1);
        exp_frames++;
        n_checks++;
        if (timed_out || q_fv.size() != NB || q_exp.size() != NB) begin
            n_fail++;
            $display("FAIL full_beats: timeout=%0d co_en=%0d model=%0d expected %0d",
                     timed_out, q_fv.size(), q_exp.size(), NB);
        end
        n_checks++;
        if (n_acc_clr != 1) begin
            n_fail++;
            $display("FAIL full_acc_clr: got %0d pulses expected 1", n_acc_clr);
        end
        for (int i = 0; i < q_fv.size() && i < q_exp.size(); i++) begin
            n_checks++;
            if (q_fv[i] != i || q_cd[i] !== q_exp[i] || q_lb[i] != int'(i == NB - 1)) begin
                n_fail++;
                $display("FAIL full_bin[%0d]: filter_v=%0d co_data=%0d last=%0d expected %0d/%0d/%0d",
                         i, q_fv[i], q_cd[i], q_lb[i], i, q_exp[i], int'(i == NB - 1));
            end
        end
        n_checks++;
        if (q_rd.size() != NM) begin
            n_fail++;
            $display("FAIL full_rd_count: got %0d expected %0d", q_rd.size(), NM);
        end
        for (int i = 0; i < q_rd.size(); i++) begin
            n_checks++;
            if (q_rd[i] != i) begin
                n_fail++;
                $display("FAIL full_rd[%0d]: got %0d expected %0d", i, q_rd[i], i);
            end
        end
        // Last co_en cycle, then COEF_LAT+1 wait cycles, then the first rd_en.
        n_checks++;
        if (first_rd_cyc - last_co_cyc != CL + 2) begin
            n_fail++;
            $display("FAIL full_drain_gap: got %0d cycles expected %0d",
                     first_rd_cyc - last_co_cyc, CL + 2);
        end
        n_checks++;
        if (n_done != 1 || frame_cnt !== 16'(exp_frames) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: done=%0d frame_cnt=%0d busy=%b expected 1/%0d/0",
                     n_done, frame_cnt, busy, exp_frames);
        end
    endtask

    // Toggling di_valid plus a 5-cycle rd_ready stall at index 17.
    task automatic test_toggle_and_stall();
        run_frame(1, 17, 5, -1, -1, 1'b0, 1'b0, -1);
        exp_frames++;
        n_checks++;
        if (timed_out || q_fv.size() != NB) begin
            n_fail++;
            $display("FAIL toggle_beats: timeout=%0d got %0d expected %0d", timed_out, q_fv.size(), NB);
        end
        for (int i = 0; i < q_fv.size() && i < q_exp.size(); i++) begin
            n_checks++;
            if (q_fv[i] != i || q_cd[i] !== q_exp[i]) begin
                n_fail++;
                $display("FAIL toggle_bin[%0d]: filter_v=%0d co_data=%0d expected %0d/%0d",
                         i, q_fv[i], q_cd[i], i, q_exp[i]);
            end
        end
        n_checks++;
        if (hold_cnt != 5) begin
            n_fail++;
            $display("FAIL stall_hold: rd_idx=17 seen stalled %0d cycles expected 5", hold_cnt);
        end
        n_checks++;
        if (q_rd.size() != NM) begin
            n_fail++;
            $display("FAIL stall_rd_count: got %0d expected %0d", q_rd.size(), NM);
        end
        for (int i = 0; i < q_rd.size(); i++) begin
            n_checks++;
            if (q_rd[i] != i) begin
                n_fail++;
                $display("FAIL stall_rd[%0d]: got %0d expected %0d", i, q_rd[i], i);
            end
        end
        n_checks++;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL stall_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames);
        end
    endtask

    // Abort with a same-cycle transfer at bin 200, then a clean restart.
    task automatic test_abort();
        run_frame(2, -1, 0, 200, -1, 1'b0, 1'b0, -1);
        n_checks++;
        if (busy !== 1'b0 || co_en !== 1'b0 || di_ready !== 1'b0 || rd_en !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b co_en=%b di_ready=%b rd_en=%b done=%b expected all 0",
                     busy, co_en, di_ready, rd_en, frame_done);
        end
        n_checks++;
        if (q_fv.size() != 200 || n_done != 0) begin
            n_fail++;
            $display("FAIL abort_beats: co_en=%0d done=%0d expected 200/0", q_fv.size(), n_done);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (frame_cnt !== 16'(exp_frames) || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_after: frame_cnt=%0d busy=%b done=%b expected %0d/0/0",
                     frame_cnt, busy, frame_done, exp_frames);
        end
        run_frame(2, -1, 0, -1, -1, 1'b0, 1'b0, -1);
        exp_frames++;
        n_checks++;
        if (timed_out || q_fv.size() != NB || n_acc_clr != 1) begin
            n_fail++;
            $display("FAIL restart_beats: timeout=%0d co_en=%0d acc_clr=%0d expected 0/%0d/1",
                     timed_out, q_fv.size(), n_acc_clr, NB);
        end
        for (int i = 0; i < q_fv.size() && i < q_exp.size(); i++) begin
            n_checks++;
            if (q_fv[i] != i || q_cd[i] !== q_exp[i]) begin
                n_fail++;
                $display("FAIL restart_bin[%0d]: filter_v=%0d co_data=%0d expected %0d/%0d",
                         i, q_fv[i], q_cd[i], i, q_exp[i]);
            end
        end
        n_checks++;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL restart_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames);
        end
    endtask

    // start during STREAM is ignored; start during DONE chains the next frame.
    task automatic test_back_to_back();
        run_frame(1, -1, 0, -1, 100, 1'b1, 1'b0, -1);
        exp_frames++;
        n_checks++;
        if (timed_out || q_fv.size() != NB || n_acc_clr != 1 || n_done != 1) begin
            n_fail++;
            $display("FAIL b2b_first: timeout=%0d co_en=%0d acc_clr=%0d done=%0d expected 0/%0d/1/1",
                     timed_out, q_fv.size(), n_acc_clr, n_done, NB);
        end
        for (int i = 0; i < q_fv.size(); i++) begin
            n_checks++;
            if (q_fv[i] != i) begin
                n_fail++;
                $display("FAIL b2b_first_bin[%0d]: got %0d expected %0d", i, q_fv[i], i);
            end
        end
        n_checks++;
        if (acc_clr !== 1'b1 || busy !== 1'b1 || di_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_restart: acc_clr=%b busy=%b di_ready=%b expected 1/1/0",
                     acc_clr, busy, di_ready);
        end
        run_frame(2, -1, 0, -1, -1, 1'b0, 1'b1, -1);
        exp_frames++;
        n_checks++;
        if (timed_out || q_fv.size() != NB || n_acc_clr != 1 || q_rd.size() != NM) begin
            n_fail++;
            $display("FAIL b2b_second: timeout=%0d co_en=%0d acc_clr=%0d rd=%0d expected 0/%0d/1/%0d",
                     timed_out, q_fv.size(), n_acc_clr, q_rd.size(), NB, NM);
        end
        for (int i = 0; i < q_fv.size() && i < q_exp.size(); i++) begin
            n_checks++;
            if (q_fv[i] != i || q_cd[i] !== q_exp[i]) begin
                n_fail++;
                $display("FAIL b2b_second_bin[%0d]: filter_v=%0d co_data=%0d expected %0d/%0d",
                         i, q_fv[i], q_cd[i], i, q_exp[i]);
            end
        end
        n_checks++;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL b2b_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames);
        end
    endtask

    // Reset dropped mid-readout must clear outputs before the next clock edge.
    task automatic test_reset_readout();
        run_frame(0, -1, 0, -1, -1, 1'b0, 1'b0, 30);
        n_checks++;
        if (rd_en !== 1'b1 || rd_idx !== 6'd30) begin
            n_fail++;
            $display("FAIL rst_rd_reach: rd_en=%b rd_idx=%0d expected 1/30", rd_en, rd_idx);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, di_ready, co_en, last_bin, acc_clr, rd_en, frame_done} !== 7'b0 ||
            rd_idx !== 6'd0 || filter_v !== 10'd0 || co_data !== '0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_async: flags=%b rd_idx=%0d filter_v=%0d frame_cnt=%0d expected all 0",
                     {busy, di_ready, co_en, last_bin, acc_clr, rd_en, frame_done},
                     rd_idx, filter_v, frame_cnt);
        end
        exp_frames = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_frame(2, -1, 0, -1, -1, 1'b0, 1'b0, -1);
        exp_frames++;
        n_checks++;
        if (timed_out || q_fv.size() != NB || n_acc_clr != 1 || frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL rst_after_frame: timeout=%0d co_en=%0d acc_clr=%0d frame_cnt=%0d expected 0/%0d/1/%0d",
                     timed_out, q_fv.size(), n_acc_clr, frame_cnt, NB, exp_frames);
        end
        for (int i = 0; i < q_fv.size(); i++) begin
            n_checks++;
            if (q_fv[i] != i) begin
                n_fail++;
                $display("FAIL rst_after_bin[%0d]: got %0d expected %0d", i, q_fv[i], i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_toggle_and_stall();
        test_abort();
        test_back_to_back();
        test_reset_readout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
